// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared IEEE-754 binary32 field widths, constants and classifier
//
// Purpose: common definitions for the FP32 arithmetic blocks.
// Contents: field widths, bias, canonical constants, unpack/classify function.
package fp32_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int WORD_W = SIGN_W + EXP_W + MANT_W;
    localparam int BIAS   = 127;

    localparam logic [WORD_W-1:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [WORD_W-1:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [WORD_W-1:0] FP32_PINF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        fp_class_e         cls;
    } fp32_unpacked_t;

    // Denormals (exp == 0) classify as zero, so callers get DAZ for free.
    function automatic fp32_unpacked_t fp32_unpack(input logic [WORD_W-1:0] x);
        fp32_unpacked_t u;
        u.sign = x[WORD_W-1];
        u.exp  = x[WORD_W-2:MANT_W];
        u.mant = x[MANT_W-1:0];
        if (u.exp == '0) begin
            u.cls = FP_ZERO;
        end else if (u.exp == '1) begin
            u.cls = (u.mant == '0) ? FP_INF : FP_NAN;
        end else begin
            u.cls = FP_NORMAL;
        end
        return u;
    endfunction

endpackage

// File: rtl/fp32_mac_core.sv
// rtl/fp32_mac_core.sv - combinational FP32 multiply then add (two roundings, FTZ/DAZ)
//
// Purpose: next_acc = round(acc + round(a * b)), round-to-nearest-even, flush-to-zero.
// Ports:
//   a_i   in  32  multiplicand
//   b_i   in  32  multiplier
//   acc_i in  32  current accumulator
//   acc_o out 32  updated accumulator
module fp32_mac_core
    import fp32_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic [WORD_W-1:0] acc_i,
    output logic [WORD_W-1:0] acc_o
);

    // Round a normalised 24-bit significand, then resolve overflow/underflow.
    function automatic logic [WORD_W-1:0] round_pack(input logic sign,
                                                     input logic signed [9:0] exp_in,
                                                     input logic [23:0] sig,
                                                     input logic guard,
                                                     input logic sticky);
        logic [24:0]       rsig;
        logic signed [9:0] e;
        rsig = {1'b0, sig} + {24'd0, guard & (sticky | sig[0])};
        e    = exp_in;
        if (rsig[24]) begin
            rsig = rsig >> 1;
            e    = e + 10'sd1;
        end
        if (e >= 10'sd255) begin
            return {sign, FP32_PINF[WORD_W-2:0]};
        end else if (e <= 10'sd0) begin
            return {sign, 31'd0};
        end
        return {sign, e[7:0], rsig[22:0]};
    endfunction

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // ---------------- multiplier stage ----------------
    fp32_unpacked_t    ua, ub;
    logic              p_sign;
    logic [47:0]       prod;
    logic signed [9:0] p_exp;
    logic [23:0]       p_sig;
    logic              p_guard, p_sticky;
    logic [WORD_W-1:0] prod_w;

    always_comb begin
        ua     = fp32_unpack(a_i);
        ub     = fp32_unpack(b_i);
        p_sign = ua.sign ^ ub.sign;
        prod   = {24'd0, 1'b1, ua.mant} * {24'd0, 1'b1, ub.mant};
        p_exp  = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - 10'(BIAS);
        // Product of two [1,2) significands lies in [1,4): at most one shift.
        if (prod[47]) begin
            p_sig    = prod[47:24];
            p_guard  = prod[23];
            p_sticky = |prod[22:0];
            p_exp    = p_exp + 10'sd1;
        end else begin
            p_sig    = prod[46:23];
            p_guard  = prod[22];
            p_sticky = |prod[21:0];
        end
        if (ua.cls == FP_NAN || ub.cls == FP_NAN ||
            (ua.cls == FP_INF && ub.cls == FP_ZERO) ||
            (ua.cls == FP_ZERO && ub.cls == FP_INF)) begin
            prod_w = FP32_QNAN;
        end else if (ua.cls == FP_INF || ub.cls == FP_INF) begin
            prod_w = {p_sign, FP32_PINF[WORD_W-2:0]};
        end else if (ua.cls == FP_ZERO || ub.cls == FP_ZERO) begin
            prod_w = {p_sign, 31'd0};
        end else begin
            prod_w = round_pack(p_sign, p_exp, p_sig, p_guard, p_sticky);
        end
    end

    // ---------------- adder stage ----------------
    fp32_unpacked_t    ux, uy, ubig, usml;
    logic              swap, eff_sub;
    logic [7:0]        exp_diff;
    logic [26:0]       big_ext, sml_ext, sml_al;
    logic [27:0]       sum;
    logic [26:0]       norm;
    logic [4:0]        lz;
    logic signed [9:0] s_exp;

    always_comb begin
        ux       = fp32_unpack(prod_w);
        uy       = fp32_unpack(acc_i);
        swap     = acc_i[WORD_W-2:0] > prod_w[WORD_W-2:0];
        ubig     = swap ? uy : ux;
        usml     = swap ? ux : uy;
        eff_sub  = ux.sign ^ uy.sign;
        exp_diff = ubig.exp - usml.exp;
        // Three extra bits below the LSB hold guard, round and sticky.
        big_ext  = {1'b1, ubig.mant, 3'b000};
        sml_ext  = {1'b1, usml.mant, 3'b000};
        if (exp_diff > 8'd26) begin
            sml_al = 27'd1;
        end else begin
            sml_al    = sml_ext >> exp_diff;
            sml_al[0] = sml_al[0] | (|(sml_ext & ~(27'h7FF_FFFF << exp_diff)));
        end
        sum   = eff_sub ? ({1'b0, big_ext} - {1'b0, sml_al})
                        : ({1'b0, big_ext} + {1'b0, sml_al});
        lz    = lzc27(sum[26:0]);
        norm  = sum[26:0] << lz;
        s_exp = $signed({2'b00, ubig.exp}) - $signed({5'd0, lz});
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            s_exp = $signed({2'b00, ubig.exp}) + 10'sd1;
        end

        if (ux.cls == FP_NAN || uy.cls == FP_NAN) begin
            acc_o = FP32_QNAN;
        end else if (ux.cls == FP_INF && uy.cls == FP_INF) begin
            acc_o = (ux.sign == uy.sign) ? prod_w : FP32_QNAN;
        end else if (ux.cls == FP_INF) begin
            acc_o = prod_w;
        end else if (uy.cls == FP_INF) begin
            acc_o = acc_i;
        end else if (ux.cls == FP_ZERO && uy.cls == FP_ZERO) begin
            acc_o = {ux.sign & uy.sign, 31'd0};
        end else if (ux.cls == FP_ZERO) begin
            acc_o = acc_i;
        end else if (uy.cls == FP_ZERO) begin
            acc_o = prod_w;
        end else if (sum == 28'd0) begin
            acc_o = FP32_ZERO;
        end else begin
            acc_o = round_pack(ubig.sign, s_exp, norm[26:3], norm[2], norm[1] | norm[0]);
        end
    end

endmodule

// File: rtl/fp32_p_element.sv
// rtl/fp32_p_element.sv - output-stationary FP32 systolic processing element
//
// Purpose: each clock, acc <= acc + IN_TOP * IN_LEFT; OUT is the acc register.
// Ports:
//   CLK     in  1   rising-edge clock
//   RST_N   in  1   synchronous reset, active-HIGH (1 = clear acc to +0.0)
//   IN_TOP  in  32  FP32 operand from the PE above
//   IN_LEFT in  32  FP32 operand from the PE to the left
//   OUT     out 32  FP32 accumulator
module fp32_p_element
    import fp32_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [WORD_W-1:0] IN_TOP,
    input  logic [WORD_W-1:0] IN_LEFT,
    output logic [WORD_W-1:0] OUT
);

    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_d;

    fp32_mac_core u_mac (
        .a_i   (IN_TOP),
        .b_i   (IN_LEFT),
        .acc_i (acc_q),
        .acc_o (acc_d)
    );

    // The name says _N but this reset is active-high.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            acc_q <= FP32_ZERO;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign OUT = acc_q;

endmodule

// File: tb/tb_fp32_p_element.sv
// tb/tb_fp32_p_element.sv - self-checking bench for fp32_p_element
module tb_fp32_p_element;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_top;
    logic [31:0] in_left;
    logic [31:0] out;

    int n_vec = 0;
    int n_err = 0;

    fp32_p_element dut (
        .CLK     (clk),
        .RST_N   (rst),
        .IN_TOP  (in_top),
        .IN_LEFT (in_left),
        .OUT     (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] top;
        logic [31:0] left;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Reference: decode to double, compute in double, round to binary32 with FTZ.
    // A double holds any binary32 product exactly, and rounding a double sum to
    // binary32 gives the correctly rounded binary32 sum.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'h00)      b = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF) b = {f[31], 11'h7FF, f[22:0], 29'd0};
        else                        b = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        int          e;
        logic [24:0] m;
        logic [28:0] rem;
        b = $realtobits(r);
        if (b[62:52] == 11'h7FF) return (b[51:0] != 52'd0) ? 32'h7FC00000 : {b[63], 31'h7F800000};
        if (b[62:52] == 11'h000) return {b[63], 31'd0};
        e   = int'(b[62:52]) - 1023 + 127;
        m   = {2'b01, b[51:29]};
        rem = b[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {b[63], 31'h7F800000};
        if (e <= 0)   return {b[63], 31'd0};
        return {b[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] model(input logic [31:0] acc, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] p;
        p = r2f(f2r(a) * f2r(b));
        return r2f(f2r(acc) + f2r(p));
    endfunction

    function automatic logic [31:0] rand_fp();
        int          k;
        logic        s;
        logic [22:0] m;
        k = int'($urandom_range(0, 39));
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        if (k == 0)  return {s, 31'd0};
        if (k == 1)  return {s, 8'hFF, 23'd0};
        if (k == 2)  return {1'b0, 8'hFF, m | 23'd1};
        if (k == 3)  return {s, 8'h00, m};
        if (k == 4)  return {s, 8'($urandom_range(200, 254)), m};
        if (k == 5)  return {s, 8'($urandom_range(1, 60)), m};
        if (k < 16)  return {s, 8'($urandom_range(90, 160)), m};
        if (k < 22)  return {s, 8'($urandom_range(126, 128)), 23'($urandom_range(0, 3))};
        return {s, 8'($urandom_range(124, 130)), m};
    endfunction

    task automatic step(input logic r, input logic [31:0] t, input logic [31:0] l);
        @(negedge clk);
        rst     = r;
        in_top  = t;
        in_left = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] want);
        n_vec++;
        if (out !== want) begin
            n_err++;
            $display("FAIL %s[%0d]: OUT=%08h expected %08h", nm, idx, out, want);
        end
    endtask

    logic        r_r;
    logic [31:0] r_t, r_l, acc_m;

    initial begin
        rst     = 1'b1;
        in_top  = 32'h0;
        in_left = 32'h0;

        // ---- directed table ----
        tbl.push_back('{1'b1, 32'h3F000000, 32'h3F000000, 32'h00000000});
        tbl.push_back('{1'b0, 32'h3F000000, 32'h3F000000, 32'h3E800000});
        tbl.push_back('{1'b0, 32'h3F000000, 32'h3F000000, 32'h3F000000});
        tbl.push_back('{1'b0, 32'h3F000000, 32'h3F000000, 32'h3F400000});
        tbl.push_back('{1'b0, 32'h3F000000, 32'h3F000000, 32'h3F800000});
        tbl.push_back('{1'b0, 32'h3F000000, 32'h3F000000, 32'h3FA00000});
        tbl.push_back('{1'b0, 32'h3F000000, 32'h3F000000, 32'h3FC00000});
        tbl.push_back('{1'b1, 32'h3F000000, 32'h3F000000, 32'h00000000});
        tbl.push_back('{1'b0, 32'h3F000000, 32'h3F000000, 32'h3E800000});
        tbl.push_back('{1'b1, 32'h00000000, 32'h00000000, 32'h00000000});
        tbl.push_back('{1'b0, 32'h40000000, 32'h40400000, 32'h40C00000});
        tbl.push_back('{1'b0, 32'hC0000000, 32'h40400000, 32'h00000000});
        tbl.push_back('{1'b1, 32'h00000000, 32'h00000000, 32'h00000000});
        tbl.push_back('{1'b0, 32'h7F800000, 32'h00000000, 32'h7FC00000});
        tbl.push_back('{1'b0, 32'h3F800000, 32'h3F800000, 32'h7FC00000});
        tbl.push_back('{1'b1, 32'h00000000, 32'h00000000, 32'h00000000});
        tbl.push_back('{1'b0, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000});
        tbl.push_back('{1'b0, 32'h3F800000, 32'h3F800000, 32'h7F800000});
        tbl.push_back('{1'b0, 32'hFF800000, 32'h3F800000, 32'h7FC00000});
        tbl.push_back('{1'b1, 32'h00000000, 32'h00000000, 32'h00000000});
        tbl.push_back('{1'b0, 32'h00400000, 32'h3F800000, 32'h00000000});
        tbl.push_back('{1'b0, 32'h0DA24260, 32'h0DA24260, 32'h00000000});
        tbl.push_back('{1'b1, 32'h00000000, 32'h00000000, 32'h00000000});
        tbl.push_back('{1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002});
        // (1 + 2^-22) - 1 = 2^-22, exponent field 105
        tbl.push_back('{1'b0, 32'hBF800000, 32'h3F800000, 32'h34800000});
        tbl.push_back('{1'b0, 32'h3F800000, 32'h80000000, 32'h34800000});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].top, tbl[i].left);
            check("table", i, tbl[i].exp);
        end

        // ---- reset held for several edges with live operands ----
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h40400000, 32'h40400000);
            check("rst_hold", i, 32'h00000000);
        end
        step(1'b0, 32'h40400000, 32'h40400000);
        check("rst_release", 0, 32'h41100000);

        // ---- NaN input stays sticky until reset ----
        step(1'b0, 32'h7F800001, 32'h3F800000);
        check("nan_in", 0, 32'h7FC00000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h3F800000, 32'h3F800000);
            check("nan_sticky", i, 32'h7FC00000);
        end
        step(1'b1, 32'h3F800000, 32'h3F800000);
        check("nan_clear", 0, 32'h00000000);
        step(1'b0, 32'h3F800000, 32'h3F800000);
        check("nan_after", 0, 32'h3F800000);

        // ---- randomized against the double-precision reference ----
        step(1'b1, 32'h0, 32'h0);
        acc_m = 32'h0;
        for (int i = 0; i < 2000; i++) begin
            r_r = ($urandom_range(0, 11) == 0);
            r_t = rand_fp();
            r_l = rand_fp();
            step(r_r, r_t, r_l);
            acc_m = r_r ? 32'h0 : model(acc_m, r_t, r_l);
            check("random", i, acc_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
